// File: rtl/mips_mem_arb_pkg.sv
// Shared types and constants for the MIPS I/D memory arbiter.
// The round-robin option is selected with MEM_ARB_RR_EN (see mips_mem_arb_pick).
package mips_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDATA,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mips_mem_arb_pick.sv
// Combinational winner select between fetch (I) and data (D) requests.
// MEM_ARB_RR_EN defined: alternate on contention; undefined: fixed priority by D_PRIORITY.
module mips_mem_arb_pick
    import mips_mem_arb_pkg::*;
#(
    parameter int unsigned D_PRIORITY = 1
) (
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_grant,
    output owner_t winner
);

`ifdef MEM_ARB_RR_EN
    localparam int unsigned unused_d_priority = D_PRIORITY;

    always_comb begin
        winner = OWN_I;
        if (i_req && d_req) begin
            winner = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            winner = OWN_D;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == OWN_D);

    always_comb begin
        winner = OWN_I;
        if (i_req && d_req) begin
            winner = (D_PRIORITY != 0) ? OWN_D : OWN_I;
        end else if (d_req) begin
            winner = OWN_D;
        end
    end
`endif

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates the CPU fetch and load/store requesters onto one Avalon-style RAM port.
// Optional round-robin contention rule enabled by defining MEM_ARB_RR_EN.
module mips_mem_arbiter
    import mips_mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned D_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [3:0]        d_be,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [DATA_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [DATA_W-1:0] writedata,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata
);

    arb_state_t        state, state_nxt;
    owner_t            winner, lat_owner, last_grant;
    logic [DATA_W-1:0] lat_addr, lat_wdata, i_rdata_q, d_rdata_q;
    logic [3:0]        lat_be;
    logic              lat_we;

    mips_mem_arb_pick #(
        .D_PRIORITY(D_PRIORITY)
    ) u_pick (
        .i_req     (i_req),
        .d_req     (d_req),
        .last_grant(last_grant),
        .winner    (winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        read      = 1'b0;
        write     = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                read  = !lat_we;
                write = lat_we;
                if (!waitrequest) begin
                    state_nxt = lat_we ? DONE : RDATA;
                end
            end
            RDATA: begin
                state_nxt = DONE;
            end
            DONE: begin
                // Requests are ignored here; a still-high req is re-sampled in IDLE.
                i_ack     = (lat_owner == OWN_I);
                d_ack     = (lat_owner == OWN_D);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_owner  <= OWN_I;
            last_grant <= OWN_I;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            lat_we     <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (state == IDLE && (i_req || d_req)) begin
                lat_owner  <= winner;
                last_grant <= winner;
                if (winner == OWN_D) begin
                    lat_addr  <= d_addr;
                    lat_be    <= d_be;
                    lat_wdata <= d_wdata;
                    lat_we    <= d_we;
                end else begin
                    lat_addr  <= i_addr;
                    lat_be    <= BE_ALL;
                    lat_wdata <= '0;
                    lat_we    <= 1'b0;
                end
            end
            if (state == RDATA) begin
                if (lat_owner == OWN_D) begin
                    d_rdata_q <= readdata;
                end else begin
                    i_rdata_q <= readdata;
                end
            end
        end
    end

    assign address    = lat_addr;
    assign byteenable = lat_be;
    assign writedata  = lat_wdata;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter with a behavioural RAM and a rule-level reference model.
module tb_mips_mem_arbiter;

    localparam int unsigned TB_DPRI = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        i_ack, d_ack;
    logic [31:0] i_rdata, d_rdata;
    logic [31:0] address, writedata, readdata;
    logic        read, write;
    logic [3:0]  byteenable;
    logic        waitrequest;

    mips_mem_arbiter #(
        .DATA_W    (32),
        .D_PRIORITY(TB_DPRI)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ack      (i_ack),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_be       (d_be),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .address    (address),
        .read       (read),
        .write      (write),
        .byteenable (byteenable),
        .writedata  (writedata),
        .waitrequest(waitrequest),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    // waitrequest source: 0 = forced low, 1 = random, 2 = manual
    int          wr_mode;
    logic        wr_rand, wr_manual;
    assign waitrequest = (wr_mode == 0) ? 1'b0 : (wr_mode == 1) ? wr_rand : wr_manual;
    always @(negedge clk) wr_rand = ($urandom_range(0, 99) < 35);

    // Behavioural word RAM (index = byte address bits [9:2]) with a preload port
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_val;
    logic [31:0] acc_addr;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        if (write && !waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) mem[address[9:2]][8*b +: 8] <= writedata[8*b +: 8];
            acc_addr <= address;
        end
        if (read && !waitrequest) begin
            readdata <= mem[address[9:2]];
            acc_addr <= address;
        end
    end

    int          checks = 0;
    int          errors = 0;
    bit          m_last_d;
    logic [31:0] rm_val;

    function automatic bit pick_d(input bit ir, input bit dr);
        if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
            return !m_last_d;
`else
            return (TB_DPRI != 0);
`endif
        end
        return dr;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = idx[7:0];
        pl_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        m_last_d = 1'b0;
    endtask

    // Drives one request per selected port (cycle 0 = this negedge) and reports what came back.
    task automatic do_pair(input bit ir, input bit dr, input logic [31:0] ia, input logic [31:0] da,
                           input bit dwe, input logic [3:0] dbe, input logic [31:0] dwd,
                           output int ic, output int dc, output logic [31:0] ird,
                           output logic [31:0] drd, output int ina, output int dna);
        int last_k;
        ic = -1; dc = -1; ina = 0; dna = 0; ird = '0; drd = '0; last_k = 0;
        i_req = ir; i_addr = ia;
        d_req = dr; d_addr = da; d_we = dwe; d_be = dbe; d_wdata = dwd;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (i_ack) begin
                ina++;
                if (ic < 0) ic = k;
                ird = i_rdata; i_req = 1'b0; last_k = k;
            end
            if (d_ack) begin
                dna++;
                if (dc < 0) dc = k;
                drd = d_rdata; d_req = 1'b0; last_k = k;
            end
            if ((!ir || ic >= 0) && (!dr || dc >= 0) && k >= last_k + 2) break;
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({read, write, i_ack, d_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0000", {read, write, i_ack, d_ack});
        end
        checks++;
        if ({address, byteenable, writedata, i_rdata, d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr %h be %h wd %h ird %h drd %h expected all 0",
                     address, byteenable, writedata, i_rdata, d_rdata);
        end
        reset = 1'b0;
        m_last_d = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({read, write, i_ack, d_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 0000", {read, write, i_ack, d_ack});
        end
    endtask

    task automatic test_i_read();
        int          ack_cyc;
        int          bad;
        logic [31:0] rd;
        preload(0, 32'h24020005);
        wr_mode = 0;
        ack_cyc = -1; bad = 0; rd = '0;
        i_req = 1'b1; i_addr = 32'hBFC00000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if ({read, write, address, byteenable} !== {1'b1, 1'b0, 32'hBFC00000, 4'hF}) begin
                    errors++;
                    $display("FAIL i_read_issue: rd %b wr %b addr %h be %h expected 1 0 bfc00000 f",
                             read, write, address, byteenable);
                end
            end
            if (d_ack) bad++;
            if (i_ack) begin
                if (ack_cyc < 0) ack_cyc = k; else bad++;
                rd = i_rdata; i_req = 1'b0;
            end
        end
        checks++;
        if (ack_cyc != 3) begin
            errors++; $display("FAIL i_read_latency: got %0d expected 3", ack_cyc);
        end
        checks++;
        if (rd !== 32'h24020005) begin
            errors++; $display("FAIL i_read_data: got %h expected 24020005", rd);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL i_read_stray_ack: got %0d expected 0", bad);
        end
        m_last_d = 1'b0;
    endtask

    task automatic test_d_write_wait();
        int ack_cyc, acks, bad;
        preload(4, 32'h11223344);
        wr_mode = 2;
        ack_cyc = -1; acks = 0; bad = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'hBFC00010; d_be = 4'b0011; d_wdata = 32'hAABBCCDD;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k <= 2 && {write, read, address, byteenable, writedata} !==
                {1'b1, 1'b0, 32'hBFC00010, 4'b0011, 32'hAABBCCDD}) bad++;
            if (k == 3 && (write !== 1'b0 || read !== 1'b0)) bad++;
            if (i_ack) bad++;
            if (d_ack) begin acks++; ack_cyc = k; d_req = 1'b0; end
            wr_manual = k[0];
        end
        ref_mem[4] = merge(ref_mem[4], 32'hAABBCCDD, 4'b0011);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL d_write_stable: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (acks != 1 || ack_cyc != 3) begin
            errors++; $display("FAIL d_write_ack: got %0d acks at %0d expected 1 at 3", acks, ack_cyc);
        end
        checks++;
        if (mem[4] !== 32'h1122CCDD) begin
            errors++; $display("FAIL d_write_ram: got %h expected 1122ccdd", mem[4]);
        end
        checks++;
        if (acc_addr !== 32'hBFC00010) begin
            errors++; $display("FAIL d_write_addr: got %h expected bfc00010", acc_addr);
        end
        wr_mode = 0;
        m_last_d = 1'b1;
    endtask

    task automatic test_wait5();
        int          ack_cyc, bad;
        logic [31:0] wd;
        wd = $urandom;
        preload(8, 32'h0);
        wr_mode = 2; wr_manual = 1'b1;
        ack_cyc = -1; bad = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'hBFC00020; d_be = 4'b1100; d_wdata = wd;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 6 && {write, read, address, byteenable, writedata} !==
                {1'b1, 1'b0, 32'hBFC00020, 4'b1100, wd}) bad++;
            if (i_ack) bad++;
            if (d_ack) begin
                if (ack_cyc < 0) ack_cyc = k; else bad++;
                d_req = 1'b0;
            end
            wr_manual = (k <= 5);
        end
        ref_mem[8] = merge(32'h0, wd, 4'b1100);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL wait5_hold: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (ack_cyc != 7) begin
            errors++; $display("FAIL wait5_ack: got %0d expected 7", ack_cyc);
        end
        checks++;
        if (mem[8] !== ref_mem[8]) begin
            errors++; $display("FAIL wait5_ram: got %h expected %h", mem[8], ref_mem[8]);
        end
        wr_mode = 0;
        m_last_d = 1'b1;
    endtask

    task automatic test_both();
        int          ic, dc, ina, dna;
        logic [31:0] ird, drd;
        bit          exp_d_first;
        do_reset();
        preload(2, $urandom);
        preload(3, $urandom);
        exp_d_first = pick_d(1'b1, 1'b1);
        do_pair(1'b1, 1'b1, 32'hBFC00008, 32'hBFC0000C, 1'b0, 4'hF, 32'h0, ic, dc, ird, drd, ina, dna);
        m_last_d = !exp_d_first;
        checks++;
        if (dc != (exp_d_first ? 3 : 7) || ic != (exp_d_first ? 7 : 3)) begin
            errors++; $display("FAIL both_order: d at %0d i at %0d expected d_first=%0d (3/7)",
                               dc, ic, exp_d_first);
        end
        checks++;
        if (ird !== ref_mem[2] || drd !== ref_mem[3]) begin
            errors++; $display("FAIL both_data: i %h d %h expected %h %h", ird, drd, ref_mem[2], ref_mem[3]);
        end
        checks++;
        if (ina != 1 || dna != 1) begin
            errors++; $display("FAIL both_ack_count: i %0d d %0d expected 1 1", ina, dna);
        end
    endtask

    task automatic test_contention();
        bit exp_seq [4];
        bit got_seq [4];
        int n, bad;
        for (int t = 0; t < 4; t++) begin
            exp_seq[t] = pick_d(1'b1, 1'b1);
            m_last_d   = exp_seq[t];
        end
        n = 0; bad = 0;
        i_req = 1'b1; i_addr = 32'hBFC00008;
        d_req = 1'b1; d_addr = 32'hBFC0000C; d_we = 1'b0; d_be = 4'hF;
        for (int k = 1; k <= 100 && n < 4; k++) begin
            @(negedge clk);
            if (i_ack && d_ack) bad++;
            if (i_ack || d_ack) begin
                got_seq[n] = d_ack;
                if (d_ack && d_rdata !== ref_mem[3]) bad++;
                if (i_ack && i_rdata !== ref_mem[2]) bad++;
                n++;
                if (n == 4) begin i_req = 1'b0; d_req = 1'b0; end
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL contention_count: got %0d grants expected 4", n);
        end
        for (int t = 0; t < 4; t++) begin
            checks++;
            if (n > t && got_seq[t] !== exp_seq[t]) begin
                errors++; $display("FAIL contention_grant%0d: got d=%0d expected d=%0d", t, got_seq[t], exp_seq[t]);
            end else if (n <= t) begin
                errors++; $display("FAIL contention_grant%0d: got none expected d=%0d", t, exp_seq[t]);
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL contention_data: got %0d bad acks expected 0", bad);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int          ic, dc, ina, dna;
        logic [31:0] ird, drd;
        rm_val = $urandom;
        preload(1, rm_val);
        wr_mode = 0;
        i_req = 1'b1; i_addr = 32'hBFC00004;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; i_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({read, write, i_ack, d_ack} !== 4'b0000) begin
            errors++; $display("FAIL reset_mid_strobes: got %b expected 0000", {read, write, i_ack, d_ack});
        end
        checks++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_mid_rdata: i %h d %h expected 0 0", i_rdata, d_rdata);
        end
        reset = 1'b0;
        m_last_d = 1'b0;
        @(negedge clk);
        do_pair(1'b1, 1'b0, 32'hBFC00004, 32'h0, 1'b0, 4'h0, 32'h0, ic, dc, ird, drd, ina, dna);
        m_last_d = 1'b0;
        checks++;
        if (ic != 3 || ird !== rm_val || ina != 1 || dna != 0) begin
            errors++; $display("FAIL reset_mid_recover: ack %0d data %h acks %0d/%0d expected 3 %h 1/0",
                               ic, ird, ina, dna, rm_val);
        end
    endtask

    task automatic test_random();
        int          ic, dc, ina, dna, bad;
        logic [31:0] ird, drd, exp_i, exp_d, m_i_rd, m_d_rd, ia, da, dwd;
        bit          ir, dr, dwe, first_d;
        logic [3:0]  dbe;
        int          iidx, didx;
        for (int w = 0; w < 16; w++) preload(w, $urandom);
        m_i_rd = rm_val;
        m_d_rd = 32'h0;
        wr_mode = 1;
        for (int it = 0; it < 40; it++) begin
            ir = $urandom_range(0, 1);
            dr = ir ? 1'($urandom_range(0, 1)) : 1'b1;
            iidx = $urandom_range(0, 15); didx = $urandom_range(0, 15);
            ia = 32'hBFC00000 + 32'(iidx * 4);
            da = 32'hBFC00000 + 32'(didx * 4);
            dwe = $urandom_range(0, 1); dbe = 4'($urandom); dwd = $urandom;
            first_d = pick_d(ir, dr);
            exp_i = m_i_rd; exp_d = m_d_rd;
            for (int s = 0; s < 2; s++) begin
                bit serve_d;
                serve_d = (s == 0) ? first_d : !first_d;
                if (serve_d && dr) begin
                    if (dwe) ref_mem[didx] = merge(ref_mem[didx], dwd, dbe);
                    else exp_d = ref_mem[didx];
                    m_last_d = 1'b1;
                end else if (!serve_d && ir) begin
                    exp_i = ref_mem[iidx];
                    m_last_d = 1'b0;
                end
            end
            do_pair(ir, dr, ia, da, dwe, dbe, dwd, ic, dc, ird, drd, ina, dna);
            checks++;
            if (ina != int'(ir) || dna != int'(dr)) begin
                errors++; $display("FAIL rand%0d_acks: i %0d d %0d expected %0d %0d", it, ina, dna, ir, dr);
            end
            checks++;
            if (ir && dr && ((dc < ic) != first_d)) begin
                errors++; $display("FAIL rand%0d_order: d at %0d i at %0d expected d_first=%0d", it, dc, ic, first_d);
            end
            checks++;
            if (i_rdata !== exp_i || d_rdata !== exp_d) begin
                errors++; $display("FAIL rand%0d_rdata: i %h d %h expected %h %h", it, i_rdata, d_rdata, exp_i, exp_d);
            end
            m_i_rd = exp_i; m_d_rd = exp_d;
        end
        wr_mode = 0;
        @(negedge clk);
        bad = 0;
        for (int w = 0; w < 16; w++) if (mem[w] !== ref_mem[w]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rand_ram: got %0d differing words expected 0", bad);
        end
    endtask

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
        wr_mode = 0; wr_manual = 1'b0;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        m_last_d = 1'b0; rm_val = '0;
        @(negedge clk);
        test_reset();
        test_i_read();
        test_d_write_wait();
        test_wait5();
        test_both();
        test_contention();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
